// File: rtl/ram_arbiter.sv
// Two-requester single-port RAM arbiter with round-robin arbitration,
// lock-based burst ownership capped at MAX_BURST and per-requester read return.
module ram_arbiter #(
  parameter int ADDRESS_WIDTH = 6,
  parameter int DATA_WIDTH    = 10,
  parameter int MAX_BURST     = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     r0_req,
  input  logic                     r0_we,
  input  logic                     r0_lock,
  input  logic [ADDRESS_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0]    r0_wdata,
  output logic                     r0_gnt,
  output logic                     r0_rvalid,
  output logic [DATA_WIDTH-1:0]    r0_rdata,
  input  logic                     r1_req,
  input  logic                     r1_we,
  input  logic                     r1_lock,
  input  logic [ADDRESS_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0]    r1_wdata,
  output logic                     r1_gnt,
  output logic                     r1_rvalid,
  output logic [DATA_WIDTH-1:0]    r1_rdata,
  output logic                     ram_we,
  output logic [ADDRESS_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0]    ram_wdata,
  input  logic [DATA_WIDTH-1:0]    ram_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] OWN0 = 2'd1;
  localparam logic [1:0] OWN1 = 2'd2;

  logic [1:0]    state, nextState;
  logic          rrLast, nextRrLast;
  logic [CW-1:0] burstCnt, nextCnt, cntInc;
  logic          gnt0, gnt1;
  logic          rdPend0, rdPend1;

  // Grant decision: combinational from registered state and live requests.
  // Reset gates grants so nothing reaches the RAM while rst is low.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          if (r0_req && r1_req) begin
            gnt0 = rrLast;
            gnt1 = !rrLast;
          end else begin
            gnt0 = r0_req;
            gnt1 = r1_req;
          end
        end
        OWN0:    gnt0 = r0_req;
        OWN1:    gnt1 = r1_req;
        default: ;
      endcase
    end
  end

  // Burst counter update and next-state selection.
  always_comb begin
    if (state == IDLE) begin
      cntInc = CW'(1);
    end else if (burstCnt >= MAX_CNT) begin
      cntInc = MAX_CNT;
    end else begin
      cntInc = burstCnt + CW'(1);
    end

    nextState  = state;
    nextRrLast = rrLast;
    nextCnt    = burstCnt;

    if (gnt0) begin
      nextCnt = cntInc;
      if (r0_lock && ((cntInc < MAX_CNT) || !r1_req)) begin
        nextState = OWN0;
      end else begin
        nextState  = IDLE;
        nextRrLast = 1'b0;
      end
    end else if (gnt1) begin
      nextCnt = cntInc;
      if (r1_lock && ((cntInc < MAX_CNT) || !r0_req)) begin
        nextState = OWN1;
      end else begin
        nextState  = IDLE;
        nextRrLast = 1'b1;
      end
    end else if (state != IDLE) begin
      // Owner dropped its request: one bubble cycle, then re-arbitrate.
      nextState = IDLE;
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rrLast   <= 1'b1;
      burstCnt <= '0;
    end else begin
      state    <= nextState;
      rrLast   <= nextRrLast;
      burstCnt <= nextCnt;
    end
  end

  // Read-return tags: remember which requester owns the data arriving next cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdPend0 <= 1'b0;
      rdPend1 <= 1'b0;
    end else begin
      rdPend0 <= gnt0 && !r0_we;
      rdPend1 <= gnt1 && !r1_we;
    end
  end

  // RAM port mux: granted requester drives the RAM, otherwise all zero.
  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (gnt0) begin
      ram_we    = r0_we;
      ram_addr  = r0_addr;
      ram_wdata = r0_wdata;
    end else if (gnt1) begin
      ram_we    = r1_we;
      ram_addr  = r1_addr;
      ram_wdata = r1_wdata;
    end
  end

  // Requester-side outputs; read data is zero unless its tag is valid.
  always_comb begin
    r0_gnt    = gnt0;
    r1_gnt    = gnt1;
    r0_rvalid = rdPend0;
    r1_rvalid = rdPend1;
    r0_rdata  = rdPend0 ? ram_rdata : '0;
    r1_rdata  = rdPend1 ? ram_rdata : '0;
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural RAM and read scoreboard.
module tb_ram_arbiter;
  localparam int AW = 6;
  localparam int DW = 10;
  localparam int MB = 4;

  logic          clk, rst;
  logic          r0_req, r0_we, r0_lock, r1_req, r1_we, r1_lock;
  logic [AW-1:0] r0_addr, r1_addr, ram_addr;
  logic [DW-1:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, ram_wdata, ram_rdata;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, ram_we;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          port;
    logic [DW-1:0] data;
  } rd_t;
  rd_t sb[$];

  logic [DW-1:0] mem[64];
  logic [DW-1:0] shadow[64];

  ram_arbiter #(.ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_lock(r0_lock), .r0_addr(r0_addr),
    .r0_wdata(r0_wdata), .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_we(r1_we), .r1_lock(r1_lock), .r1_addr(r1_addr),
    .r1_wdata(r1_wdata), .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous RAM: one-cycle read latency.
  always @(posedge clk) begin
    if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic req, we, lock, input int addr, input int data);
    r0_req = req; r0_we = we; r0_lock = lock;
    r0_addr = AW'(addr); r0_wdata = DW'(data);
  endtask

  task automatic drive1(input logic req, we, lock, input int addr, input int data);
    r1_req = req; r1_we = we; r1_lock = lock;
    r1_addr = AW'(addr); r1_wdata = DW'(data);
  endtask

  task automatic checkReads(input string tag);
    rd_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(r0_rvalid, !e.port, {tag, " r0_rvalid"});
      chk(r1_rvalid, e.port, {tag, " r1_rvalid"});
      chk(e.port ? r1_rdata : r0_rdata, e.data, {tag, " rdata"});
      chk(e.port ? r0_rdata : r1_rdata, 0, {tag, " idle rdata"});
    end else begin
      chk(r0_rvalid, 0, {tag, " r0_rvalid idle"});
      chk(r1_rvalid, 0, {tag, " r1_rvalid idle"});
      chk(r0_rdata, 0, {tag, " r0_rdata idle"});
      chk(r1_rdata, 0, {tag, " r1_rdata idle"});
    end
  endtask

  task automatic step(input logic eg0, input logic eg1, input string tag);
    rd_t e;
    @(negedge clk);
    checkReads(tag);
    chk(r0_gnt, eg0, {tag, " r0_gnt"});
    chk(r1_gnt, eg1, {tag, " r1_gnt"});
    if (eg0) begin
      chk(ram_we, r0_we, {tag, " ram_we"});
      chk(ram_addr, r0_addr, {tag, " ram_addr"});
      chk(ram_wdata, r0_wdata, {tag, " ram_wdata"});
      if (r0_we) shadow[r0_addr] = r0_wdata;
      else begin e.port = 1'b0; e.data = shadow[r0_addr]; sb.push_back(e); end
    end else if (eg1) begin
      chk(ram_we, r1_we, {tag, " ram_we"});
      chk(ram_addr, r1_addr, {tag, " ram_addr"});
      chk(ram_wdata, r1_wdata, {tag, " ram_wdata"});
      if (r1_we) shadow[r1_addr] = r1_wdata;
      else begin e.port = 1'b1; e.data = shadow[r1_addr]; sb.push_back(e); end
    end else begin
      chk(ram_we, 0, {tag, " ram_we none"});
      chk(ram_addr, 0, {tag, " ram_addr none"});
      chk(ram_wdata, 0, {tag, " ram_wdata none"});
    end
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned seq[8];
    int r1cnt;
    for (int i = 0; i < 64; i++) begin mem[i] = '0; shadow[i] = '0; end
    ram_rdata = '0;
    rst = 1'b0;
    drive0(1, 0, 1, 3, 0);
    drive1(1, 0, 1, 4, 0);

    // Reset held with both requesting: nothing may be granted or returned.
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk(r0_gnt, 0, "rst r0_gnt");
      chk(r1_gnt, 0, "rst r1_gnt");
      chk(r0_rvalid, 0, "rst r0_rvalid");
      chk(r1_rvalid, 0, "rst r1_rvalid");
      chk(ram_we, 0, "rst ram_we");
      @(posedge clk); #1;
    end
    rst = 1'b1;

    // Contended writes without lock: alternate starting with r0.
    for (int i = 0; i < 6; i++) begin
      drive0(1, 1, 0, i, 100 + i);
      drive1(1, 1, 0, 32 + i, 200 + i);
      step((i % 2) == 0, (i % 2) == 1, $sformatf("alt wr %0d", i));
    end
    // Contended reads: tags must follow the requester.
    for (int i = 0; i < 4; i++) begin
      drive0(1, 0, 0, i, 0);
      drive1(1, 0, 0, 32 + i, 0);
      step((i % 2) == 0, (i % 2) == 1, $sformatf("alt rd %0d", i));
    end
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step(0, 0, "alt flush");

    // r0 write then read of address 52.
    drive0(1, 1, 0, 52, 15);
    step(1, 0, "wr52");
    drive0(1, 0, 0, 52, 0);
    step(1, 0, "rd52");
    drive0(0, 1, 1, 9, 9);
    drive1(0, 1, 1, 8, 8);
    step(0, 0, "rd52 ret");

    // Owner drops request while locked: one bubble, then r1.
    drive0(1, 1, 1, 10, 77);
    step(1, 0, "lock0");
    drive0(0, 0, 0, 0, 0);
    drive1(1, 1, 0, 11, 88);
    step(0, 0, "bubble");
    step(0, 1, "after bubble");
    drive1(0, 0, 0, 0, 0);

    // r1 locked for 6 accesses, r0 idle: no cap applies.
    for (int k = 0; k < 6; k++) begin
      drive1(1, 1, k < 5, 20 + k, 300 + k);
      step(0, 1, $sformatf("lock1 solo %0d", k));
    end
    drive1(0, 0, 0, 0, 0);
    step(0, 0, "solo end");

    // r1 locked for 6 accesses with r0 waiting: 4, r0, 2, r0.
    seq = '{1, 1, 1, 1, 0, 1, 1, 0};
    r1cnt = 0;
    for (int c = 0; c < 8; c++) begin
      drive0(c >= 1, 1, 0, 40, 500 + c);
      drive1(r1cnt < 6, 1, r1cnt < 5, 44 + c, 600 + c);
      step(seq[c] == 0, seq[c] == 1, $sformatf("burst cap %0d", c));
      if (seq[c] == 1) r1cnt++;
    end
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step(0, 0, "burst end");

    // Reset pulsed while an r1 read is outstanding.
    drive1(1, 0, 0, 33, 0);
    @(negedge clk);
    chk(r1_gnt, 1, "prerst r1_gnt");
    chk(r0_gnt, 0, "prerst r0_gnt");
    #2 rst = 1'b0;
    drive0(1, 0, 0, 0, 0);
    drive1(1, 0, 0, 33, 0);
    @(posedge clk); #1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk(r1_rvalid, 0, "midrst r1_rvalid");
      chk(r0_rvalid, 0, "midrst r0_rvalid");
      chk(r1_gnt, 0, "midrst r1_gnt");
      @(posedge clk); #1;
    end
    rst = 1'b1;
    step(1, 0, "postrst first");
    step(0, 1, "postrst second");
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step(0, 0, "postrst flush");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
